// File: rtl/core_mem_requester_pkg.sv
// Shared definitions for the core memory requester: FSM encoding and the
// layout of a buffered command record {write, address, wdata}.
package core_mem_requester_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Command record layout, LSB first: wdata, then address, then the write flag.
    function automatic int cmd_wdata_ofs(input int width);
        cmd_wdata_ofs = 0;
    endfunction

    function automatic int cmd_addr_ofs(input int width);
        cmd_addr_ofs = width;
    endfunction

    function automatic int cmd_write_ofs(input int width);
        cmd_write_ofs = 2 * width;
    endfunction

    function automatic int cmd_bits(input int width);
        cmd_bits = 2 * width + 1;
    endfunction

endpackage

// File: rtl/core_mem_requester_req_fifo.sv
// Small synchronous command FIFO with show-ahead head output and full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module req_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_mem_requester.sv
// Buffers core memory commands and issues them one at a time to the arbiter,
// returning a single-cycle completion (data, store flag, or timeout error).
module core_mem_requester
    import core_mem_requester_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int FIFO_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [WIDTH-1:0] cmd_address,
    input  logic [WIDTH-1:0] cmd_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_write,
    output logic             rsp_error,
    output logic             request,
    input  logic             response,
    output logic [WIDTH-1:0] address,
    output logic [WIDTH-1:0] data_out,
    input  logic [WIDTH-1:0] data_in,
    output logic             wren
);

    localparam int CMD_W     = cmd_bits(WIDTH);
    localparam int WDATA_OFS = cmd_wdata_ofs(WIDTH);
    localparam int ADDR_OFS  = cmd_addr_ofs(WIDTH);
    localparam int WRITE_OFS = cmd_write_ofs(WIDTH);
    localparam int CNT_W     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [CMD_W-1:0] w_cmd_in;
    logic [CMD_W-1:0] w_cmd_head;

    state_t           r_state,    w_state_next;
    logic [CNT_W-1:0] r_count,    w_count_next;
    logic             r_request,  w_request_next;
    logic             r_wren,     w_wren_next;
    logic [WIDTH-1:0] r_address,  w_address_next;
    logic [WIDTH-1:0] r_data_out, w_data_out_next;
    logic             r_rsp_valid, w_rsp_valid_next;
    logic [WIDTH-1:0] r_rsp_data,  w_rsp_data_next;
    logic             r_rsp_write, w_rsp_write_next;
    logic             r_rsp_error, w_rsp_error_next;

    assign w_cmd_in  = {cmd_write, cmd_address, cmd_wdata};
    assign w_push    = cmd_valid && !w_full;
    assign cmd_ready = !w_full;

    req_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (w_cmd_in),
        .i_pop   (w_pop),
        .o_rdata (w_cmd_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_next     = r_state;
        w_count_next     = r_count;
        w_request_next   = r_request;
        w_wren_next      = r_wren;
        w_address_next   = r_address;
        w_data_out_next  = r_data_out;
        w_rsp_valid_next = 1'b0;
        w_rsp_data_next  = r_rsp_data;
        w_rsp_write_next = r_rsp_write;
        w_rsp_error_next = 1'b0;
        w_pop            = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A response arriving here is stray and deliberately ignored.
                if (!w_empty) begin
                    w_pop           = 1'b1;
                    w_address_next  = w_cmd_head[ADDR_OFS +: WIDTH];
                    w_data_out_next = w_cmd_head[WDATA_OFS +: WIDTH];
                    w_wren_next     = w_cmd_head[WRITE_OFS];
                    w_request_next  = 1'b1;
                    w_count_next    = '0;
                    w_state_next    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Response is checked first so it wins over a same-cycle timeout.
                if (response) begin
                    w_request_next   = 1'b0;
                    w_wren_next      = 1'b0;
                    w_rsp_valid_next = 1'b1;
                    w_rsp_data_next  = data_in;
                    w_rsp_write_next = r_wren;
                    w_state_next     = ST_IDLE;
                end else if (r_count == CNT_LAST) begin
                    w_request_next   = 1'b0;
                    w_wren_next      = 1'b0;
                    w_rsp_valid_next = 1'b1;
                    w_rsp_error_next = 1'b1;
                    w_rsp_data_next  = '0;
                    w_rsp_write_next = r_wren;
                    w_state_next     = ST_IDLE;
                end else begin
                    w_count_next = r_count + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_request   <= 1'b0;
            r_wren      <= 1'b0;
            r_address   <= '0;
            r_data_out  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_write <= 1'b0;
            r_rsp_error <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_count     <= w_count_next;
            r_request   <= w_request_next;
            r_wren      <= w_wren_next;
            r_address   <= w_address_next;
            r_data_out  <= w_data_out_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_data  <= w_rsp_data_next;
            r_rsp_write <= w_rsp_write_next;
            r_rsp_error <= w_rsp_error_next;
        end
    end

    assign request   = r_request;
    assign wren      = r_wren;
    assign address   = r_address;
    assign data_out  = r_data_out;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_write = r_rsp_write;
    assign rsp_error = r_rsp_error;

endmodule

// File: tb/tb_core_mem_requester.sv
// Self-checking bench for core_mem_requester: command table plus hand sequences,
// a behavioural arbiter, and a completion scoreboard.
module tb_core_mem_requester;

    localparam int W       = 32;
    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 8;
    localparam int NEVER   = 0;   // arbiter delay meaning "never respond"
    localparam int NVEC    = 6;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
    } arb_t;

    typedef struct {
        logic        wr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        arb_t cmd;
        exp_t exp;
    } vec_t;

    logic          clk;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [W-1:0]  cmd_address;
    logic [W-1:0]  cmd_wdata;
    logic          rsp_valid;
    logic [W-1:0]  rsp_data;
    logic          rsp_write;
    logic          rsp_error;
    logic          request;
    logic          response;
    logic [W-1:0]  address;
    logic [W-1:0]  data_out;
    logic [W-1:0]  data_in;
    logic          wren;

    int   n_cmp;
    int   n_fail;
    int   n_rsp;
    logic stray_pulse;

    arb_t arb_q[$];
    exp_t exp_q[$];
    arb_t arb_cur;
    logic arb_active;
    int   arb_cnt;
    vec_t vecs [NVEC];

    core_mem_requester #(
        .WIDTH          (W),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_address (cmd_address),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_write   (rsp_write),
        .rsp_error   (rsp_error),
        .request     (request),
        .response    (response),
        .address     (address),
        .data_out    (data_out),
        .data_in     (data_in),
        .wren        (wren)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Behavioural arbiter: answers each request after its programmed delay and
    // checks that the presented command is correct and held stable.
    initial begin
        response   = 1'b0;
        data_in    = '0;
        arb_active = 1'b0;
        arb_cnt    = 0;
        forever begin
            @(negedge clk);
            response = 1'b0;
            data_in  = $urandom;
            if (reset) begin
                arb_active = 1'b0;
                arb_cnt    = 0;
                arb_q.delete();
            end else if (stray_pulse) begin
                response    = 1'b1;
                stray_pulse = 1'b0;
            end else if (request) begin
                if (!arb_active) begin
                    if (arb_q.size() == 0) begin
                        chk("unexpected_request", 32'(request), 32'd0);
                    end else begin
                        arb_cur    = arb_q[0];
                        arb_active = 1'b1;
                        arb_cnt    = 0;
                    end
                end
                if (arb_active) begin
                    chk("arb_address", address, arb_cur.addr);
                    chk("arb_wren", 32'(wren), 32'(arb_cur.wr));
                    if (arb_cur.wr) chk("arb_data_out", data_out, arb_cur.wdata);
                    arb_cnt++;
                    if (arb_cur.delay != NEVER && arb_cnt == arb_cur.delay) begin
                        response = 1'b1;
                        data_in  = arb_cur.rdata;
                        void'(arb_q.pop_front());
                        arb_active = 1'b0;
                    end
                end
            end else if (arb_active) begin
                chk("timeout_request_cycles", 32'(arb_cnt), 32'(TIMEOUT));
                void'(arb_q.pop_front());
                arb_active = 1'b0;
            end
        end
    end

    // Completion monitor / scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else if (rsp_valid) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_write", 32'(rsp_write), 32'(e.wr));
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_error", 32'(rsp_error), 32'(e.err));
                $display("rsp: write=%0d data=0x%08h error=%0d", rsp_write, rsp_data, rsp_error);
            end
        end
    end

    task automatic push_cmd(input arb_t a, input exp_t e);
        for (int k = 0; k < 100 && !cmd_ready; k++) @(negedge clk);
        if (!cmd_ready) begin
            chk("push_wait_ready", 32'(cmd_ready), 32'd1);
            return;
        end
        cmd_valid   = 1'b1;
        cmd_write   = a.wr;
        cmd_address = a.addr;
        cmd_wdata   = a.wdata;
        arb_q.push_back(a);
        exp_q.push_back(e);
        $display("cmd: write=%0d addr=0x%08h wdata=0x%08h delay=%0d", a.wr, a.addr, a.wdata, a.delay);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 200 && (exp_q.size() != 0 || arb_q.size() != 0); k++) @(negedge clk);
        if (exp_q.size() != 0 || arb_q.size() != 0)
            chk("drain_pending", 32'(exp_q.size() + arb_q.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arb_t a;
        exp_t e;
        int   rsp_before;

        n_cmp = 0; n_fail = 0; n_rsp = 0;
        stray_pulse = 1'b0;
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_wdata = '0;

        vecs[0] = '{'{1'b0, 32'h10,       32'h0,        4,     32'hDEADBEEF}, '{1'b0, 32'hDEADBEEF, 1'b0}};
        vecs[1] = '{'{1'b1, 32'h20,       32'h12345678, 3,     32'hA5A50001}, '{1'b1, 32'hA5A50001, 1'b0}};
        vecs[2] = '{'{1'b0, 32'h30,       32'h0,        NEVER, 32'h0},        '{1'b0, 32'h0,        1'b1}};
        vecs[3] = '{'{1'b0, 32'h44,       32'h0,        8,     32'hCAFEF00D}, '{1'b0, 32'hCAFEF00D, 1'b0}};
        vecs[4] = '{'{1'b1, 32'hFFFFFFFF, 32'h0,        1,     32'h0BADF00D}, '{1'b1, 32'h0BADF00D, 1'b0}};
        vecs[5] = '{'{1'b0, 32'h7,        32'h0,        7,     32'h13572468}, '{1'b0, 32'h13572468, 1'b0}};

        repeat (3) @(negedge clk);
        chk("reset_request", 32'(request), 32'd0);
        chk("reset_wren", 32'(wren), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_write", 32'(rsp_write), 32'd0);
        chk("reset_rsp_error", 32'(rsp_error), 32'd0);
        chk("reset_address", address, 32'd0);
        chk("reset_data_out", data_out, 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        reset = 1'b0;
        @(negedge clk);

        // No bypass: request rises one edge after the push edge, not on it.
        a = '{1'b0, 32'h40, 32'h0, 2, 32'h55AA55AA};
        e = '{1'b0, 32'h55AA55AA, 1'b0};
        push_cmd(a, e);
        chk("no_bypass_request", 32'(request), 32'd0);
        @(negedge clk);
        chk("request_latency", 32'(request), 32'd1);
        drain();

        for (int i = 0; i < NVEC; i++) begin
            push_cmd(vecs[i].cmd, vecs[i].exp);
            drain();
        end

        // Back-to-back: with one command outstanding, two more fill the FIFO.
        a = '{1'b0, 32'h100, 32'h0, 6, 32'h11111111};
        push_cmd(a, '{1'b0, 32'h11111111, 1'b0});
        for (int k = 0; k < 20 && !request; k++) @(negedge clk);
        chk("b2b_first_request", 32'(request), 32'd1);
        push_cmd('{1'b1, 32'h104, 32'hBBBB0000, 2, 32'h22222222}, '{1'b1, 32'h22222222, 1'b0});
        chk("b2b_ready_after_one", 32'(cmd_ready), 32'd1);
        push_cmd('{1'b0, 32'h108, 32'h0, 3, 32'h33333333}, '{1'b0, 32'h33333333, 1'b0});
        chk("b2b_ready_full", 32'(cmd_ready), 32'd0);
        push_cmd('{1'b1, 32'h10C, 32'hDDDD0000, 1, 32'h44444444}, '{1'b1, 32'h44444444, 1'b0});
        drain();
        chk("b2b_ready_after_drain", 32'(cmd_ready), 32'd1);

        // Reset while waiting, then a stray response must be ignored.
        push_cmd('{1'b0, 32'h200, 32'h0, NEVER, 32'h0}, '{1'b0, 32'h0, 1'b1});
        for (int k = 0; k < 20 && !request; k++) @(negedge clk);
        chk("rst_wait_request", 32'(request), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_wait_request_dropped", 32'(request), 32'd0);
        chk("rst_wait_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        rsp_before = n_rsp;
        @(negedge clk);
        stray_pulse = 1'b1;
        repeat (5) @(negedge clk);
        chk("stray_no_rsp", 32'(n_rsp), 32'(rsp_before));
        chk("stray_request", 32'(request), 32'd0);
        chk("stray_cmd_ready", 32'(cmd_ready), 32'd1);

        // Still functional after the reset.
        push_cmd('{1'b1, 32'h300, 32'h87654321, 2, 32'h99990000}, '{1'b1, 32'h99990000, 1'b0});
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
